// File: rtl/fp_sum_driver.sv
// fp_sum_driver
//   Streams IEEE-754 binary32 packet elements into an external floating-point
//   adder and accumulates the packet total. The adder does all the arithmetic;
//   this block only sequences the operand and result handshakes, tracks the
//   element count and flags any NaN result seen in the packet.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   in_data_i/vld/last/rdy   input element stream
//   add_a_o/vld/rdy          accumulator operand channel to the adder
//   add_b_o/vld/rdy          element operand channel to the adder
//   add_res_i/vld/rdy        adder result channel
//   sum_o, sum_nan_o,
//   sum_cnt_o, sum_vld/rdy   packet total channel
//   busy_o                   high while a packet element is in flight or a
//                            total is waiting to be taken
//
// FSM states
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | post-reset, everything quiet; moves to S_LOAD next cycle
//   S_LOAD  | in_rdy high, waiting for the next element
//   S_ISSUE | presenting acc / element to the adder, per-channel handshake
//   S_WAIT  | add_res_rdy high, waiting for the adder sum
//   S_DONE  | sum_vld high, holding the total until sum_rdy

module fp_sum_driver #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      in_data_i,
  input  logic             in_vld_i,
  input  logic             in_last_i,
  output logic             in_rdy_o,
  output logic [31:0]      add_a_o,
  output logic [31:0]      add_b_o,
  output logic             add_a_vld_o,
  output logic             add_b_vld_o,
  input  logic             add_a_rdy_i,
  input  logic             add_b_rdy_i,
  input  logic [31:0]      add_res_i,
  input  logic             add_res_vld_i,
  output logic             add_res_rdy_o,
  output logic [31:0]      sum_o,
  output logic             sum_nan_o,
  output logic [CNT_W-1:0] sum_cnt_o,
  output logic             sum_vld_o,
  input  logic             sum_rdy_i,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      elem_q, elem_d;
  logic             last_q, last_d;
  logic             nan_q, nan_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Per-channel "operand still owed to the adder" flags, only meaningful in S_ISSUE.
  logic             a_pend_q, a_pend_d;
  logic             b_pend_q, b_pend_d;

  logic             res_is_nan;
  logic             a_left;
  logic             b_left;

  assign res_is_nan = (add_res_i[30:23] == 8'hFF) && (add_res_i[22:0] != 23'd0);

  // An operand is still outstanding after this edge if it is pending and not taken now.
  assign a_left = a_pend_q && !add_a_rdy_i;
  assign b_left = b_pend_q && !add_b_rdy_i;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      acc_q    <= 32'h0000_0000;
      elem_q   <= 32'h0000_0000;
      last_q   <= 1'b0;
      nan_q    <= 1'b0;
      cnt_q    <= '0;
      a_pend_q <= 1'b0;
      b_pend_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      elem_q   <= elem_d;
      last_q   <= last_d;
      nan_q    <= nan_d;
      cnt_q    <= cnt_d;
      a_pend_q <= a_pend_d;
      b_pend_q <= b_pend_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    elem_d   = elem_q;
    last_d   = last_q;
    nan_d    = nan_q;
    cnt_d    = cnt_q;
    a_pend_d = a_pend_q;
    b_pend_d = b_pend_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_LOAD;
      end

      S_LOAD: begin
        if (in_vld_i) begin
          elem_d   = in_data_i;
          last_d   = in_last_i;
          if (!(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          // Both operands are offered together on ISSUE entry, without waiting on rdy.
          a_pend_d = 1'b1;
          b_pend_d = 1'b1;
          state_d  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (add_a_rdy_i) begin
          a_pend_d = 1'b0;
        end
        if (add_b_rdy_i) begin
          b_pend_d = 1'b0;
        end
        if (!a_left && !b_left) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (add_res_vld_i) begin
          acc_d = add_res_i;
          if (res_is_nan) begin
            nan_d = 1'b1;
          end
          state_d = last_q ? S_DONE : S_LOAD;
        end
      end

      S_DONE: begin
        if (sum_rdy_i) begin
          acc_d   = 32'h0000_0000;
          nan_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs, all decoded from registered state
  always_comb begin
    in_rdy_o      = 1'b0;
    add_a_vld_o   = 1'b0;
    add_b_vld_o   = 1'b0;
    add_res_rdy_o = 1'b0;
    sum_vld_o     = 1'b0;
    busy_o        = 1'b0;

    case (state_q)
      S_LOAD: begin
        in_rdy_o = 1'b1;
      end
      S_ISSUE: begin
        add_a_vld_o = a_pend_q;
        add_b_vld_o = b_pend_q;
        busy_o      = 1'b1;
      end
      S_WAIT: begin
        add_res_rdy_o = 1'b1;
        busy_o        = 1'b1;
      end
      S_DONE: begin
        sum_vld_o = 1'b1;
        busy_o    = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  // Operand and sum data come straight from the registers, so they are
  // naturally stable while a valid is waiting for its ready.
  assign add_a_o   = acc_q;
  assign add_b_o   = elem_q;
  assign sum_o     = acc_q;
  assign sum_nan_o = nan_q;
  assign sum_cnt_o = cnt_q;

  // Handshake properties
  a_hold_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    add_a_vld_o && !add_a_rdy_i |=> add_a_vld_o && $stable(add_a_o));

  b_hold_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    add_b_vld_o && !add_b_rdy_i |=> add_b_vld_o && $stable(add_b_o));

  issue_entry_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    in_vld_i && in_rdy_o |=> add_a_vld_o && add_b_vld_o);

  sum_hold_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    sum_vld_o && !sum_rdy_i |=> sum_vld_o && $stable(sum_o) &&
                                $stable(sum_cnt_o) && $stable(sum_nan_o));

  load_not_busy_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    in_rdy_o |-> !busy_o && !add_res_rdy_o && !sum_vld_o);

endmodule

// File: tb/tb_fp_sum_driver.sv
// tb_fp_sum_driver
//   Self-checking bench for fp_sum_driver. A behavioural floating-point adder
//   (binary32 widened to real, added, truncated back) sits on the operand and
//   result channels; packet totals are predicted by folding the same addition
//   over the element list starting from +0.0.

module tb_fp_sum_driver;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   in_data;
  logic          in_vld, in_last, in_rdy;
  logic [31:0]   add_a, add_b, add_res;
  logic          add_a_vld, add_b_vld, add_a_rdy, add_b_rdy;
  logic          add_res_vld, add_res_rdy;
  logic [31:0]   sum;
  logic          sum_nan, sum_vld, sum_rdy, busy;
  logic [CW-1:0] sum_cnt;

  always #5 clk = ~clk;

  fp_sum_driver #(.CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_data_i(in_data), .in_vld_i(in_vld), .in_last_i(in_last), .in_rdy_o(in_rdy),
    .add_a_o(add_a), .add_b_o(add_b), .add_a_vld_o(add_a_vld), .add_b_vld_o(add_b_vld),
    .add_a_rdy_i(add_a_rdy), .add_b_rdy_i(add_b_rdy),
    .add_res_i(add_res), .add_res_vld_i(add_res_vld), .add_res_rdy_o(add_res_rdy),
    .sum_o(sum), .sum_nan_o(sum_nan), .sum_cnt_o(sum_cnt), .sum_vld_o(sum_vld),
    .sum_rdy_i(sum_rdy), .busy_o(busy)
  );

  // ---------------- floating-point reference helpers ----------------
  function automatic logic [63:0] f2d(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'h00) return {f[31], 63'd0};
    if (f[30:23] == 8'hFF) return {f[31], 11'h7FF, f[22:0], 29'd0};
    e = 11'(f[30:23]) + 11'd896;
    return {f[31], e, f[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] d2f(input logic [63:0] d);
    int e;
    logic [22:0] m;
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    if (d[62:52] == 11'h7FF) begin
      m = d[51:29];
      if (m == 23'd0 && d[51:0] != 52'd0) m = 23'd1;
      return {d[63], 8'hFF, m};
    end
    e = int'(d[62:52]) - 896;
    if (e <= 0) return {d[63], 31'd0};
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], 8'(e), d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return d2f($realtobits($bitstoreal(f2d(a)) + $bitstoreal(f2d(b))));
  endfunction

  function automatic bit is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction

  // ---------------- behavioural adder: registered, one cycle after both operands ----------------
  logic        a_fix, b_fix, rnd_mode;
  logic        a_rnd = 1'b1, b_rnd = 1'b1;
  assign add_a_rdy = rnd_mode ? a_rnd : a_fix;
  assign add_b_rdy = rnd_mode ? b_rnd : b_fix;

  always @(posedge clk) begin
    a_rnd <= ($urandom_range(0, 2) != 0);
    b_rnd <= ($urandom_range(0, 2) != 0);
  end

  logic        got_a, got_b, pend, ha, hb;
  logic [31:0] va, vb, xa, xb, pend_val;
  logic [31:0] a_seen[$];
  logic [31:0] b_seen[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      got_a <= 1'b0; got_b <= 1'b0; pend <= 1'b0;
      va <= '0; vb <= '0; pend_val <= '0;
      add_res_vld <= 1'b0; add_res <= '0;
    end else begin
      ha = got_a; hb = got_b; xa = va; xb = vb;
      if (add_a_vld && add_a_rdy) begin ha = 1'b1; xa = add_a; a_seen.push_back(add_a); end
      if (add_b_vld && add_b_rdy) begin hb = 1'b1; xb = add_b; b_seen.push_back(add_b); end
      if (add_res_vld && add_res_rdy) add_res_vld <= 1'b0;
      if (pend) begin add_res_vld <= 1'b1; add_res <= pend_val; end
      pend <= 1'b0;
      if (ha && hb) begin pend <= 1'b1; pend_val <= fadd(xa, xb); ha = 1'b0; hb = 1'b0; end
      got_a <= ha; got_b <= hb; va <= xa; vb <= xb;
    end
  end

  // ---------------- bench bookkeeping ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk, n_fail, acc_cyc;
  logic [31:0] pkt[$];

  typedef struct packed {
    logic [2:0]       n;
    logic [3:0][31:0] e;
    logic [31:0]      sum;
    logic             nan;
    logic [3:0]       cnt;
  } vec_t;
  vec_t tbl[6];

  task automatic set_vec(input int i, input int n, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3, input logic [31:0] s,
                         input bit nan, input int cnt);
    tbl[i].n = 3'(n);
    tbl[i].e[0] = e0; tbl[i].e[1] = e1; tbl[i].e[2] = e2; tbl[i].e[3] = e3;
    tbl[i].sum = s; tbl[i].nan = nan; tbl[i].cnt = 4'(cnt);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input bit last, input int gap);
    int n;
    in_vld = 1'b0;
    repeat (gap) step();
    in_data = d; in_last = last; in_vld = 1'b1;
    n = 0;
    while (!in_rdy && n < 200) begin step(); n++; end
    if (!in_rdy) check("accept_timeout", in_rdy, 1);
    else begin acc_cyc = cyc; step(); end
    in_vld = 1'b0; in_last = 1'b0;
  endtask

  task automatic collect(input logic [31:0] exp_sum, input bit exp_nan, input bit exp_only,
                         input int exp_cnt, input int hold, input bit chk_lat);
    int n;
    logic [31:0] s0;
    logic [CW-1:0] c0;
    logic nan0;
    n = 0;
    while (!sum_vld && n < 300) begin step(); n++; end
    if (!sum_vld) begin check("sum_vld_timeout", sum_vld, 1); return; end
    if (chk_lat) check("latency", cyc - acc_cyc, 4);
    if (exp_only) begin
      check("sum_exp", sum[30:23], 8'hFF);
      check("sum_mant_nz", (sum[22:0] != 23'd0), 1);
    end else check("sum", sum, exp_sum);
    check("sum_nan", sum_nan, exp_nan);
    check("sum_cnt", sum_cnt, exp_cnt);
    s0 = sum; c0 = sum_cnt; nan0 = sum_nan;
    sum_rdy = 1'b0;
    for (int h = 0; h < hold; h++) begin
      step();
      check("hold_sum", sum, s0);
      check("hold_cnt_nan", {sum_cnt, sum_nan}, {c0, nan0});
      check("hold_vld_rdy", {sum_vld, in_rdy}, 2'b10);
    end
    sum_rdy = 1'b1;
    step();
    sum_rdy = 1'b0;
    check("after_take_vld_rdy", {sum_vld, in_rdy}, 2'b01);
    check("after_take_clear", {sum, sum_cnt, sum_nan}, 0);
  endtask

  task automatic run_pkt(input logic [31:0] exp_sum, input bit exp_nan, input bit exp_only,
                         input int exp_cnt, input int hold, input bit chk_lat, input int gap_max);
    int a_base, b_base;
    logic [31:0] accm;
    logic [31:0] ea[$];
    a_base = a_seen.size(); b_base = b_seen.size();
    accm = 32'h0;
    foreach (pkt[i]) begin ea.push_back(accm); accm = fadd(accm, pkt[i]); end
    foreach (pkt[i]) send(pkt[i], i == pkt.size() - 1, $urandom_range(0, gap_max));
    collect(exp_sum, exp_nan, exp_only, exp_cnt, hold, chk_lat);
    check("a_beats", a_seen.size() - a_base, pkt.size());
    check("b_beats", b_seen.size() - b_base, pkt.size());
    if (a_seen.size() - a_base == pkt.size() && b_seen.size() - b_base == pkt.size())
      foreach (pkt[i]) begin
        check("op_a", a_seen[a_base + i], ea[i]);
        check("op_b", b_seen[b_base + i], pkt[i]);
      end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int a_base, b_base, len;
    logic [31:0] ms, e;
    bit mn;
    n_chk = 0; n_fail = 0; acc_cyc = 0;
    rst_n = 1'b0; in_vld = 1'b0; in_last = 1'b0; in_data = '0; sum_rdy = 1'b0;
    a_fix = 1'b1; b_fix = 1'b1; rnd_mode = 1'b0;

    // reset state
    repeat (2) @(posedge clk); #1;
    check("rst_ctl", {in_rdy, add_a_vld, add_b_vld, add_res_rdy, sum_vld, busy, sum_nan}, 0);
    check("rst_ops", {add_a, add_b}, 0);
    check("rst_sum", {sum, sum_cnt}, 0);
    #3 rst_n = 1'b1;
    check("idle_after_release", {in_rdy, busy}, 0);
    step();
    check("load_after_idle", {in_rdy, busy}, 2'b10);

    // directed table
    set_vec(0, 3, 32'h3F800000, 32'h40000000, 32'h40400000, 0, 32'h40C00000, 0, 3);
    set_vec(1, 1, 32'h80000000, 0, 0, 0, 32'h00000000, 0, 1);
    set_vec(2, 2, 32'h3F800000, 32'h7FC00000, 0, 0, 32'h0, 1, 2);
    set_vec(3, 1, 32'h40000000, 0, 0, 0, 32'h40000000, 0, 1);
    set_vec(4, 2, 32'hBF800000, 32'h3F800000, 0, 0, 32'h00000000, 0, 2);
    set_vec(5, 4, 32'h3FC00000, 32'h40200000, 32'hC0800000, 32'h3F000000, 32'h3F000000, 0, 4);
    for (int i = 0; i < 6; i++) begin
      pkt.delete();
      for (int k = 0; k < int'(tbl[i].n); k++) pkt.push_back(tbl[i].e[k]);
      run_pkt(tbl[i].sum, tbl[i].nan, tbl[i].nan, int'(tbl[i].cnt), 0, 1, 0);
    end

    // total held for 10 cycles with sum_rdy low
    pkt.delete(); pkt.push_back(32'h3F800000); pkt.push_back(32'h3F800000);
    run_pkt(32'h40000000, 0, 0, 2, 10, 1, 0);

    // element counter saturates at all-ones
    pkt.delete();
    for (int k = 0; k < 17; k++) pkt.push_back(32'h3F800000);
    run_pkt(32'h41880000, 0, 0, 15, 0, 1, 0);

    // add_a_rdy held low 5 cycles while add_b is taken at once
    a_base = a_seen.size(); b_base = b_seen.size();
    send(32'h3F800000, 0, 0);
    step();
    a_fix = 1'b0;
    send(32'h40A00000, 1, 0);
    for (int i = 0; i < 5; i++) begin
      check("a_vld_held", add_a_vld, 1);
      check("a_data_held", add_a, 32'h3F800000);
      check("b_vld_once", add_b_vld, i == 0);
      step();
    end
    check("a_vld_still", add_a_vld, 1);
    a_fix = 1'b1;
    step();
    check("issue_exit", {add_a_vld, add_b_vld, add_res_rdy}, 3'b001);
    collect(32'h40C00000, 0, 0, 2, 0, 0);
    check("bp_a_beats", a_seen.size() - a_base, 2);
    check("bp_b_beats", b_seen.size() - b_base, 2);

    // asynchronous reset during WAIT
    send(32'h40000000, 1, 0);
    step();
    check("in_wait", {busy, add_res_rdy}, 2'b11);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_ctl", {in_rdy, add_a_vld, add_b_vld, add_res_rdy, sum_vld, busy, sum_nan}, 0);
    check("async_rst_ops", {add_a, add_b}, 0);
    check("async_rst_sum", {sum, sum_cnt}, 0);
    step();
    #3 rst_n = 1'b1;
    check("idle_after_rst", {in_rdy, busy}, 0);
    step();
    check("load_after_rst", {in_rdy, sum}, {1'b1, 32'h0});
    pkt.delete(); pkt.push_back(32'h3F800000);
    run_pkt(32'h3F800000, 0, 0, 1, 0, 1, 0);

    // randomized packets with adder backpressure, input gaps and sum holds
    rnd_mode = 1'b1;
    for (int p = 0; p < 25; p++) begin
      pkt.delete();
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 19) == 0) e = 32'h7FC00000;
        else e = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
        pkt.push_back(e);
      end
      ms = 32'h0; mn = 1'b0;
      foreach (pkt[k]) begin ms = fadd(ms, pkt[k]); if (is_nan(ms)) mn = 1'b1; end
      run_pkt(ms, mn, 0, len, $urandom_range(0, 3), 0, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
